// File: rtl/cdda_pkg.sv
// Shared constants, types and helpers for the CD-DA serial audio transmitter.
package cdda_pkg;

  localparam int CDDA_FRAME_W        = 32;
  localparam int CDDA_SAMPLE_W       = 16;
  localparam int CDDA_BITS_PER_FRAME = 32;

  typedef logic [CDDA_FRAME_W-1:0] cdda_frame_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } cdda_state_e;

  // Left word occupies bits 0-15 of the frame, right word bits 16-31.
  function automatic logic lrck_for_bit(input logic [4:0] bit_idx);
    return (bit_idx < 5'(CDDA_SAMPLE_W));
  endfunction

endpackage

// File: rtl/cdda_tx_fifo.sv
// Synchronous frame FIFO, 2**AW entries, with registered level/full/empty flags.
module cdda_tx_fifo
  import cdda_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        push,
  input  cdda_frame_t push_data,
  input  logic        pop,
  output cdda_frame_t pop_data,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  cdda_frame_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_nx;
  logic          do_push;
  logic          do_pop;

  // A write is only accepted while there is room; a pop never exceeds contents.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: combinational blocks assign a default first so no path leaves level_nx unassigned (no latch).
  always_comb begin
    level_nx = level;
    case ({do_push, do_pop})
      2'b10:   level_nx = level + LVL_ONE;
      2'b01:   level_nx = level - LVL_ONE;
      default: level_nx = level;
    endcase
  end

  // NOTE: storage array carries no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_nx;
      full  <= (level_nx == LVL_FULL);
      empty <= (level_nx == '0);
    end
  end

endmodule

// File: rtl/cdda_serial_tx.sv
// CD-DA serial transmitter: FIFO-fed frames serialised as BCLK/LRCK/SDAT, 32 BCLK per frame.
// Build option CDDA_TX_REPEAT_EN: on underrun resend the previous frame instead of digital silence.
module cdda_serial_tx
  import cdda_pkg::*;
#(
  parameter int FIFO_AW   = 2,
  parameter int BCLK_HALF = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic [31:0]        wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               underrun,
  input  logic               underrun_clr,
  output logic               bclk,
  output logic               lrck,
  output logic               sdat
);

  localparam int               DIV_W   = $clog2(BCLK_HALF);
  localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(BCLK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [4:0]       BIT_LAST = 5'(CDDA_BITS_PER_FRAME - 1);

  cdda_state_e      state;
  logic [DIV_W-1:0] div;
  logic [4:0]       bit_cnt;
  cdda_frame_t      shreg;
  cdda_frame_t      load_frame;
  cdda_frame_t      fill_frame;
  cdda_frame_t      fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             in_load;
  logic             fifo_pop;
  logic             underrun_set;
  logic             bclk_q;
  logic             lrck_q;
  logic             sdat_q;
  logic             underrun_q;

  cdda_tx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_load      = en && (state == ST_LOAD);
  assign fifo_pop     = in_load && !fifo_empty;
  assign underrun_set = in_load && fifo_empty;
  assign load_frame   = fifo_empty ? fill_frame : fifo_rd_data;

`ifdef CDDA_TX_REPEAT_EN
  cdda_frame_t last_frame;

  always_ff @(posedge clk) begin
    if (!nrst)         last_frame <= '0;
    else if (fifo_pop) last_frame <= fifo_rd_data;
  end

  assign fill_frame = last_frame;
`else
  assign fill_frame = '0;
`endif

  // Dropping en behaves like a soft reset of the serialiser; the FIFO is left alone.
  always_ff @(posedge clk) begin
    if (!nrst || !en) begin
      state   <= ST_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b1;
      sdat_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_LOAD;
        ST_LOAD: begin
          // LOAD counts as the first clk of bit 0's low half, keeping the frame at 64*BCLK_HALF.
          shreg   <= load_frame;
          sdat_q  <= load_frame[CDDA_FRAME_W-1];
          lrck_q  <= 1'b1;
          bclk_q  <= 1'b0;
          div     <= DIV_ONE;
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div == DIV_TC) begin
            div    <= '0;
            bclk_q <= ~bclk_q;
            if (bclk_q) begin
              if (bit_cnt == BIT_LAST) begin
                state <= ST_LOAD;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                shreg   <= {shreg[CDDA_FRAME_W-2:0], 1'b0};
                sdat_q  <= shreg[CDDA_FRAME_W-2];
                lrck_q  <= lrck_for_bit(bit_cnt + 5'd1);
              end
            end
          end else begin
            div <= div + DIV_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (!nrst)             underrun_q <= 1'b0;
    else if (underrun_set) underrun_q <= 1'b1;
    else if (underrun_clr) underrun_q <= 1'b0;
  end

  assign wr_ready = ~fifo_full;
  assign underrun = underrun_q;
  assign bclk     = bclk_q;
  assign lrck     = lrck_q;
  assign sdat     = sdat_q;

endmodule

// File: tb/tb_cdda_serial_tx.sv
// Self-checking bench for cdda_serial_tx: frame-level reference model fed by randomized traffic.
// Honours CDDA_TX_REPEAT_EN for the expected underrun fill frame.
module tb_cdda_serial_tx;

  localparam int H         = 8;
  localparam int FIFO_AW   = 2;
  localparam int DEPTH     = 1 << FIFO_AW;

  logic             clk = 1'b0;
  logic             nrst;
  logic             en;
  logic [31:0]      wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [FIFO_AW:0] fifo_level;
  logic             underrun;
  logic             underrun_clr;
  logic             bclk;
  logic             lrck;
  logic             sdat;

  cdda_serial_tx #(
    .FIFO_AW   (FIFO_AW),
    .BCLK_HALF (H)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .bclk         (bclk),
    .lrck         (lrck),
    .sdat         (sdat)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames in the order the link must emit them.
  logic [31:0] exp_q[$];
  logic [31:0] last_frame = '0;
  logic [31:0] cur_exp    = '0;
  logic [31:0] got_d, got_l;
  int          mon_bits    = 0;
  int          frames_done = 0;
  int          cyc         = 0;
  int          last_rise   = -1;
  int          last_start  = -1;
  logic        prev_bclk   = 1'b0;

  // Receiver view: sample SDAT/LRCK on each BCLK rise, judge whole frames.
  always @(negedge clk) begin
    cyc++;
    if (!nrst || !en) begin
      mon_bits   = 0;
      last_rise  = -1;
      last_start = -1;
      if (!nrst) begin
        exp_q.delete();
        last_frame  = '0;
        frames_done = 0;
      end
    end else if (bclk && !prev_bclk) begin
      if (last_rise >= 0) check("bclk_period", cyc - last_rise, 2 * H);
      last_rise = cyc;
      if (mon_bits == 0) begin
        if (last_start >= 0) check("frame_period", cyc - last_start, 64 * H);
        last_start = cyc;
        if (exp_q.size() > 0) begin
          cur_exp    = exp_q.pop_front();
          last_frame = cur_exp;
        end else begin
`ifdef CDDA_TX_REPEAT_EN
          cur_exp = last_frame;
`else
          cur_exp = '0;
`endif
        end
      end
      got_d = {got_d[30:0], sdat};
      got_l = {got_l[30:0], lrck};
      mon_bits++;
      if (mon_bits == 32) begin
        check("frame_sdat", got_d, cur_exp);
        check("frame_lrck", got_l, 32'hFFFF_0000);
        mon_bits = 0;
        frames_done++;
      end
    end
    prev_bclk = bclk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] d, output int waited);
    logic rdy;
    waited   = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = wr_ready;
      tick();
      waited++;
      if (rdy) break;
      if (waited > 3000) begin
        check("push_timeout", 0, 1);
        break;
      end
    end
    if (rdy) exp_q.push_back(d);
    wr_valid = 1'b0;
  endtask

  task automatic wait_progress(input int frames, input int bits);
    int n = 0;
    while (!(frames_done >= frames && mon_bits >= bits)) begin
      tick();
      n++;
      if (n > 20000) begin
        check("wait_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bclk"}, bclk, 1'b0);
    check({tag, "_lrck"}, lrck, 1'b1);
    check({tag, "_sdat"}, sdat, 1'b0);
  endtask

  task automatic clear_underrun();
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    @(negedge clk);
    check("underrun_cleared", underrun, 1'b0);
    tick();
  endtask

  int   w;
  int   base;
  logic prev_l;

  initial begin
    nrst = 1'b0; en = 1'b0; wr_data = '0; wr_valid = 1'b0; underrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("rst");
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun, 1'b0);
    tick();
    nrst = 1'b1;
    tick();

    // Known pattern, then an underrun frame.
    push_frame(32'h8001_7FFE, w);
    en = 1'b1;
    wait_progress(2, 5);
    check("underrun_set", underrun, 1'b1);
    en = 1'b0;
    tick();
    clear_underrun();

    // Coincident set and clear: set must win on the LOAD edge.
    en = 1'b1;
    underrun_clr = 1'b1;
    prev_l = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (lrck && !prev_l) break;
      prev_l = lrck;
      w++;
      if (w > 2000) begin
        check("load_timeout", 0, 1);
        break;
      end
    end
    check("underrun_set_wins", underrun, 1'b1);
    @(negedge clk);
    check("underrun_clr_after", underrun, 1'b0);
    tick();
    underrun_clr = 1'b0;
    en = 1'b0;
    tick();

    // Fill the FIFO; a fifth offer waits for the first pop.
    for (int i = 0; i < DEPTH; i++) push_frame($urandom, w);
    @(negedge clk);
    check("full_wr_ready", wr_ready, 1'b0);
    check("full_level", fifo_level, DEPTH);
    tick();
    base = frames_done;
    en = 1'b1;
    push_frame($urandom, w);
    check("held_accept_edges", w, 3);
    @(negedge clk);
    check("refill_level", fifo_level, DEPTH);
    tick();
    wait_progress(base + 5, 5);
    en = 1'b0;
    tick();
    @(negedge clk);
    check("drained_level", fifo_level, 0);
    check("drained_underrun", underrun, 1'b1);
    tick();

    // Reset in the middle of a frame.
    push_frame($urandom, w);
    push_frame($urandom, w);
    en = 1'b1;
    wait_progress(frames_done, 10);
    nrst = 1'b0;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("midrst");
    check("midrst_level", fifo_level, 0);
    check("midrst_underrun", underrun, 1'b0);
    check("midrst_wr_ready", wr_ready, 1'b1);
    tick();
    nrst = 1'b1;
    tick();

    // en dropped at bit 20 with two frames queued behind the current one.
    for (int i = 0; i < 3; i++) push_frame($urandom, w);
    en = 1'b1;
    wait_progress(frames_done, 20);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("endrop");
    check("endrop_level", fifo_level, 2);
    tick();
    en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("restart_level", fifo_level, 1);
    tick();
    base = frames_done;
    wait_progress(base + 2, 5);
    en = 1'b0;
    tick();

    // Randomized bursts: queue some frames, stream a random number of them.
    for (int it = 0; it < 6; it++) begin
      int space, n, total, k;
      clear_underrun();
      space = DEPTH - exp_q.size();
      n = (space > 0) ? $urandom_range(space, 1) : 0;
      for (int i = 0; i < n; i++) push_frame($urandom, w);
      total = exp_q.size();
      k = $urandom_range(total, 0);
      base = frames_done;
      en = 1'b1;
      wait_progress(base + k, 5);
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("burst_level", fifo_level, exp_q.size());
      check("burst_underrun", underrun, (k >= total) ? 1 : 0);
      tick();
    end

    // Continuous streaming with the producer keeping the FIFO topped up.
    clear_underrun();
    while (exp_q.size() < DEPTH) push_frame($urandom, w);
    base = frames_done;
    en = 1'b1;
    wr_valid = 1'b1;
    wr_data = $urandom;
    w = 0;
    while (frames_done < base + 8 && w < 8000) begin
      logic rdy;
      @(negedge clk);
      rdy = wr_ready;
      tick();
      w++;
      if (rdy) begin
        exp_q.push_back(wr_data);
        wr_data = $urandom;
      end
    end
    wr_valid = 1'b0;
    if (w >= 8000) check("stream_timeout", 0, 1);
    @(negedge clk);
    check("stream_underrun", underrun, 1'b0);
    tick();
    wait_progress(base + 8, 5);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("stream_level", fifo_level, exp_q.size());
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
